// File: rtl/lib_arbiter_pkg.sv
// Shared definitions for the pixel-group arbitration hierarchy.
//   CONST1        : group grid side used by the level-1 array
//   NUM_GROUPS1   : number of level-1 groups (CONST1*CONST1)
//   GRP_IDX_W     : width of a group row/column index (minimum 1)
//   sched_state_t : top scheduler FSM states
//   clog2_min1    : $clog2 clamped to at least 1 bit
package lib_arbiter_pkg;

  localparam int CONST1      = 2;
  localparam int NUM_GROUPS1 = CONST1 * CONST1;
  localparam int GRP_IDX_W   = (CONST1 > 1) ? $clog2(CONST1) : 1;

  typedef enum logic {IDLE, GRANT} sched_state_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/group_rr_scheduler_if.sv
// Bundle between the group scheduler and the pixel-group array.
//   enable_i      : scan enable (array/control side -> scheduler)
//   req_i         : per-group request array
//   grp_release_i : granted group has finished
//   gnt_o         : registered one-hot group grant
//   valid_o       : a grant is active
//   grp_row_o/col : coordinates of the granted group, 0 when idle
//   timeout_o     : one-cycle pulse on forced grant end
//   active_o      : any request pending or grant active
// modport master : scheduler side; modport slave : array side.
interface group_rr_scheduler_if
  import lib_arbiter_pkg::*;
#(
  parameter int GRID = CONST1
);
  logic                       enable_i;
  logic [GRID-1:0][GRID-1:0]  req_i;
  logic                       grp_release_i;
  logic [GRID-1:0][GRID-1:0]  gnt_o;
  logic                       valid_o;
  logic [GRP_IDX_W-1:0]       grp_row_o;
  logic [GRP_IDX_W-1:0]       grp_col_o;
  logic                       timeout_o;
  logic                       active_o;

  modport master (
    input  enable_i, req_i, grp_release_i,
    output gnt_o, valid_o, grp_row_o, grp_col_o, timeout_o, active_o
  );

  modport slave (
    output enable_i, req_i, grp_release_i,
    input  gnt_o, valid_o, grp_row_o, grp_col_o, timeout_o, active_o
  );
endinterface

// File: rtl/group_rr_scheduler_pick.sv
// rr_priority_pick: combinational round-robin selector.
//   req_i   : flat request vector, N bits
//   ptr_i   : index with highest priority this cycle
//   gnt_o   : one-hot grant of the first requester at or after ptr_i
//   idx_o   : index of that requester
//   found_o : at least one request present
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      // Explicit wrap compare so group counts need not be powers of two.
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!found_o && req_i[cand_idx]) begin
        found_o         = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/group_rr_scheduler.sv
// group_rr_scheduler: grants one level-1 pixel group at a time in
// row-major round-robin order and holds the grant until the group
// releases, withdraws its request, or HOLD_MAX cycles elapse.
//   clk_i, reset_i : clock, synchronous active-high reset
//   bus (master)   : request/grant bundle, see group_rr_scheduler_if
// Parameters: GRID (grid side), HOLD_MAX (hold limit, 0 = no limit).
module group_rr_scheduler
  import lib_arbiter_pkg::*;
#(
  parameter int GRID     = CONST1,
  parameter int HOLD_MAX = 64
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  group_rr_scheduler_if.master bus
);

  localparam int N     = GRID * GRID;
  localparam int IDX_W = clog2_min1(N);
  localparam int HC_W  = clog2_min1(HOLD_MAX + 1);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [HC_W-1:0]  HOLD_SAT  = HC_W'(HOLD_MAX);

  sched_state_t         state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [HC_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [N-1:0]         gnt_q, gnt_d;
  logic [GRP_IDX_W-1:0] row_q, row_d;
  logic [GRP_IDX_W-1:0] col_q, col_d;
  logic                 timeout_q, timeout_d;

  logic [N-1:0]     req_flat;
  logic [N-1:0]     pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             released;
  logic             timed_out;

  // 2-D group array <-> flat row-major index
  for (genvar r = 0; r < GRID; r++) begin : g_row
    for (genvar c = 0; c < GRID; c++) begin : g_col
      assign req_flat[r*GRID+c] = bus.req_i[r][c];
      assign bus.gnt_o[r][c]    = gnt_q[r*GRID+c];
    end
  end

  rr_priority_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req_flat),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Release or withdrawal beats the timeout when both land together.
  assign released  = bus.grp_release_i || ((req_flat & gnt_q) == '0);
  assign timed_out = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    row_d      = row_q;
    col_d      = col_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable_i && pick_found) begin
          state_d    = GRANT;
          gnt_d      = pick_gnt;
          idx_d      = pick_idx;
          row_d      = GRP_IDX_W'(int'(pick_idx) / GRID);
          col_d      = GRP_IDX_W'(int'(pick_idx) % GRID);
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (released || timed_out) begin
          state_d   = IDLE;
          gnt_d     = '0;
          row_d     = '0;
          col_d     = '0;
          ptr_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          timeout_d = !released;
        end else if (hold_cnt_q != HOLD_SAT) begin
          // Saturating so HOLD_MAX=0 (no limit) never wraps the counter.
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State / output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.valid_o   = |gnt_q;
  assign bus.grp_row_o = row_q;
  assign bus.grp_col_o = col_q;
  assign bus.timeout_o = timeout_q;
  assign bus.active_o  = (|req_flat) || (|gnt_q);

endmodule

// File: doc/group_rr_scheduler.md
# group_rr_scheduler

Top-level round-robin scheduler for the level-1 pixel groups. It takes the 2-D group request array, grants exactly one group at a time, and holds that grant while the group's internal arbiter drains its pixel events. It advances on group release, on request withdrawal, or on a hold timeout. It sits above the pixel-group array and drives that array's `gnt_top_i`; the array's `grp_release_o` and `req_o` feed back into it.

## Interface
Parameters:
- `GRID`, default `CONST1`: group grid side; the block schedules `GRID*GRID` groups.
- `HOLD_MAX`, default 64: maximum cycles one grant may be held. 0 disables the timeout.

Ports:
- `clk_i`, in, 1: clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `enable_i`, in, 1: scan enable. While low, no new grant is issued.
- `req_i`, in, `[GRID-1:0][GRID-1:0]`: per-group event request.
- `grp_release_i`, in, 1: the granted group has finished and releases its grant.
- `gnt_o`, out, `[GRID-1:0][GRID-1:0]`: registered one-hot (or zero) group grant.
- `valid_o`, out, 1: a grant is active; equals `|gnt_o`.
- `grp_row_o`, out, `GRP_IDX_W`: row of the granted group; 0 when idle.
- `grp_col_o`, out, `GRP_IDX_W`: column of the granted group; 0 when idle.
- `timeout_o`, out, 1: one-cycle pulse when a grant is forcibly ended by `HOLD_MAX`.
- `active_o`, out, 1: combinational; high when any `req_i` bit is set or `valid_o` is high.

## Operation
- Flat index: `idx = row*GRID + col`. Priority is row-major from the pointer `ptr`, wrapping at `GRID*GRID-1` back to 0. Wrap uses an explicit compare, so non-power-of-2 counts work.
- States: `IDLE` and `GRANT`.
- In `IDLE`, when `enable_i` is high and any `req_i` bit is set:
  - Select the first requester at or after `ptr`.
  - Register its one-hot grant and its row/column.
  - Clear `hold_cnt`.
  - Go to `GRANT`.
- In `GRANT`, `gnt_o` is held constant and `hold_cnt` increments every cycle. The grant ends on the first of these:
  - (a) `grp_release_i` is high.
  - (b) `req_i` of the granted group is low (withdrawn).
  - (c) `HOLD_MAX != 0` and `hold_cnt == HOLD_MAX-1`, which also pulses `timeout_o`.
- On grant end: `ptr` becomes granted `idx + 1` with wrap, `gnt_o`, row and column clear, and the state returns to `IDLE`.
- Precedence when end conditions coincide: (a) or (b) wins over (c). `timeout_o` is not pulsed when release or withdrawal occurs in the timeout cycle.
- `enable_i` falling during `GRANT` does not abort the grant; the grant completes normally.
- `grp_release_i` in `IDLE` is ignored.
- Requests from non-granted groups never disturb the current grant.
- Fairness: a continuously requesting group is granted within `GRID*GRID` grants.
- `hold_cnt` width is `$clog2(HOLD_MAX+1)`, minimum 1. It resets on every new grant and never wraps in use.

## Timing
- Reset (sync, takes effect at the edge where `reset_i` is high): `state=IDLE`, `ptr=0`, `hold_cnt=0`, `gnt_o=0`, `valid_o=0`, `grp_row_o=0`, `grp_col_o=0`, `timeout_o=0`. Reset mid-grant drops `gnt_o` at the next edge.
- Request-to-grant latency: `req_i` sampled in `IDLE` at edge t gives `gnt_o` valid after edge t (1 cycle).
- Release latency: `grp_release_i` sampled at edge t drops `gnt_o` after edge t. Every grant is followed by at least one cycle with `gnt_o=0`, so the group's enable visibly falls. The earliest next grant follows edge t+1.
- Back-to-back throughput: at most one grant per 2 cycles when every release is immediate.
- Timeout: with the grant first visible after edge g and no release, `gnt_o` drops and `timeout_o` pulses after edge g+`HOLD_MAX`.

## Structure
- `lib_arbiter_pkg` holds:
  - `CONST1` and `NUM_GROUPS1`, existing.
  - New `GRP_IDX_W = $clog2(CONST1)` (minimum 1).
  - New `typedef enum logic {IDLE, GRANT} sched_state_t`.
- Sub-module `rr_priority_pick`: combinational. Inputs are a flat request vector of N bits and `ptr`. Outputs are a one-hot grant, the index, and a found flag. It is reusable by other hierarchy levels.
- The top module holds the FSM, `ptr`, `hold_cnt`, the output registers, and the 2-D to flat mapping.

## Test plan
- Reset then single request: `GRID=2`, `req_i[1][0]=1` → after 1 cycle `gnt_o[1][0]=1`, `grp_row_o=1`, `grp_col_o=0`. On `grp_release_i` the next cycle, `gnt_o=0`.
- Round robin: all 4 requests held high with immediate releases → grant order `idx` 0,1,2,3,0, each separated by one zero cycle.
- Timeout: `HOLD_MAX=4`, request held, no release → grant lasts exactly 4 cycles, `timeout_o` pulses once, next grant goes to `idx+1`.
- Simultaneous events: release in the timeout cycle gives `timeout_o=0`. Withdrawal of the granted request ends the grant next cycle. Other requests toggling during `GRANT` leave `gnt_o` unchanged.
- Enable and reset: `enable_i=0` with requests present → no grant. `enable_i` falling mid-grant → grant persists until release. `reset_i` mid-grant → `gnt_o=0` and `ptr=0` next cycle, then `idx` 0 has priority.
